// File: rtl/fp_round_norm.sv
// rtl/fp_round_norm.sv - FP add last stage: round (RNE), renormalise carry-out, pack word, flag overflow/inexact.
// Optional FP_RND_MODES_EN adds a rnd_mode port (RNE/RTZ/+inf/-inf); undefined builds are RNE only.
module fp_round_norm #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   res,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic [EXP_W:0]         in_exp,
    input  logic [MAN_W+3:0]       in_man,
`ifdef FP_RND_MODES_EN
    input  logic [1:0]             rnd_mode,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   overflow,
    output logic                   inexact
);

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_RENORM, S_DONE} state_t;

    localparam logic [EXP_W:0]   EXP_ONES = {1'b0, {EXP_W{1'b1}}};
    localparam logic [EXP_W-1:0] EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};

    state_t                 state_q, state_d;
    logic                   sign_q, sign_d;
    logic [EXP_W:0]         exp_q, exp_d;
    logic [MAN_W+3:0]       man_q, man_d;
    logic [MAN_W-1:0]       sum_q, sum_d;
    logic [EXP_W+MAN_W:0]   result_q, result_d;
    logic                   overflow_q, overflow_d;
    logic                   inexact_q, inexact_d;
    logic [1:0]             mode;

`ifdef FP_RND_MODES_EN
    logic [1:0]             mode_q, mode_d;
    assign mode = mode_q;
`else
    assign mode = 2'b00;
`endif

    logic                   lsb, g, r, s, up, sat_max, ovf_w;
    logic [MAN_W+1:0]       sum_w;
    logic [EXP_W:0]         pk_exp;
    logic [MAN_W-1:0]       pk_frac;
    logic [EXP_W+MAN_W:0]   pk_result;

    always_comb begin
        lsb = man_q[3];
        g   = man_q[2];
        r   = man_q[1];
        s   = man_q[0];
        case (mode)
            2'b00:   up = g & (r | s | lsb);
            2'b01:   up = 1'b0;
            2'b10:   up = ~sign_q & (g | r | s);
            default: up = sign_q & (g | r | s);
        endcase
        sum_w = {1'b0, man_q[MAN_W+3:3]} + {{(MAN_W+1){1'b0}}, up};

        pk_exp  = exp_q;
        pk_frac = sum_w[MAN_W-1:0];
        if (state_q == S_RENORM) begin
            pk_exp  = exp_q + {{EXP_W{1'b0}}, 1'b1};
            pk_frac = sum_q;
        end else if (exp_q == '0 && sum_w[MAN_W]) begin
            // Denormal rounded up into the hidden bit becomes the smallest normal.
            pk_exp = {{EXP_W{1'b0}}, 1'b1};
        end

        // Upstream overflow bit is checked on exp_q so a RENORM wrap cannot hide it.
        ovf_w   = exp_q[EXP_W] | (pk_exp >= EXP_ONES);
        sat_max = (mode == 2'b01) | ((mode == 2'b10) & sign_q) | ((mode == 2'b11) & ~sign_q);
        if (!ovf_w)
            pk_result = {sign_q, pk_exp[EXP_W-1:0], pk_frac};
        else if (sat_max)
            pk_result = {sign_q, EXP_MAXF, {MAN_W{1'b1}}};
        else
            pk_result = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end

    always_comb begin
        state_d    = state_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        man_d      = man_q;
        sum_d      = sum_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        inexact_d  = inexact_q;
`ifdef FP_RND_MODES_EN
        mode_d     = mode_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    exp_d   = in_exp;
                    man_d   = in_man;
`ifdef FP_RND_MODES_EN
                    mode_d  = rnd_mode;
`endif
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                if (sum_w[MAN_W+1]) begin
                    sum_d   = sum_w[MAN_W:1];
                    state_d = S_RENORM;
                end else begin
                    result_d   = pk_result;
                    overflow_d = ovf_w;
                    inexact_d  = g | r | s;
                    state_d    = S_DONE;
                end
            end
            S_RENORM: begin
                result_d   = pk_result;
                overflow_d = ovf_w;
                inexact_d  = g | r | s;
                state_d    = S_DONE;
            end
            default: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q    <= S_IDLE;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            man_q      <= '0;
            sum_q      <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            inexact_q  <= 1'b0;
`ifdef FP_RND_MODES_EN
            mode_q     <= 2'b00;
`endif
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            man_q      <= man_d;
            sum_q      <= sum_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            inexact_q  <= inexact_d;
`ifdef FP_RND_MODES_EN
            mode_q     <= mode_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign overflow  = overflow_q;
    assign inexact   = inexact_q;

endmodule

// File: tb/tb_fp_round_norm.sv
// tb/tb_fp_round_norm.sv - self-checking bench for fp_round_norm (EXP_W=8, MAN_W=23).
module tb_fp_round_norm;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [8:0]  in_exp = '0;
    logic [26:0] in_man = '0;
    logic [1:0]  rnd_mode = 2'b00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        overflow;
    logic        inexact;

    int n_tests = 0;
    int n_fail  = 0;

    fp_round_norm #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .res(res),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_man(in_man),
`ifdef FP_RND_MODES_EN
        .rnd_mode(rnd_mode),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow), .inexact(inexact)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [8:0]  e;
        logic [26:0] m;
        logic [1:0]  md;
        logic [31:0] r;
        logic        ov;
        logic        ix;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    function automatic logic [26:0] mk(input logic h, input logic [22:0] f, input logic [2:0] grs);
        return {h, f, grs};
    endfunction

    function automatic void add(input logic s, input logic [8:0] e, input logic [26:0] m, input logic [1:0] md,
                                input logic [31:0] r, input logic ov, input logic ix, input int lat);
        vec_t v;
        v.s = s; v.e = e; v.m = m; v.md = md; v.r = r; v.ov = ov; v.ix = ix; v.lat = lat;
        vecs.push_back(v);
    endfunction

    // Reference: treat the significand as an integer plus a remainder in eighths of an ulp.
    function automatic void model(input logic s, input logic [8:0] e, input logic [26:0] m, input logic [1:0] md,
                                  output logic [31:0] r, output logic ov, output logic ix, output int lat);
        longint mant, rem, mm;
        int     ee;
        bit     up, sat;
        mant = longint'(m[26:3]);
        rem  = longint'(m[2:0]);
        case (md)
            2'd0:    up = (rem > 4) || (rem == 4 && (mant % 2) == 1);
            2'd1:    up = 0;
            2'd2:    up = (rem != 0) && !s;
            default: up = (rem != 0) && s;
        endcase
        mm  = mant + (up ? 1 : 0);
        ee  = int'(e);
        lat = 2;
        if (mm >= (64'd1 << 24)) begin
            mm  = mm / 2;
            ee  = ee + 1;
            lat = 3;
        end else if (ee == 0 && mm >= (64'd1 << 23)) begin
            ee = 1;
        end
        ix  = (rem != 0);
        ov  = (int'(e) >= 256) || (ee >= 255);
        sat = (md == 2'd1) || (md == 2'd2 && s) || (md == 2'd3 && !s);
        if (!ov)
            r = {s, 8'(ee), 23'(mm)};
        else if (sat)
            r = {s, 8'hFE, 23'h7FFFFF};
        else
            r = {s, 8'hFF, 23'h0};
    endfunction

    task automatic apply(input logic s, input logic [8:0] e, input logic [26:0] m, input logic [1:0] md,
                         output logic [31:0] r, output logic ov, output logic ix, output int lat);
        @(posedge clk); #1;
        chk("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
        in_sign = s; in_exp = e; in_man = m; rnd_mode = md; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        r = result; ov = overflow; ix = inexact;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_after_drain", {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] r, er;
        logic        ov, ix, eov, eix;
        int          lat, elat;
        logic        s, h;
        logic [8:0]  e;
        logic [22:0] f;
        logic [2:0]  grs;
        logic [1:0]  md;
        int          k;

        add(0, 9'h07F, mk(1, 23'h000000, 3'b000), 0, 32'h3F800000, 0, 0, 2);
        add(0, 9'h07F, mk(1, 23'h000001, 3'b100), 0, 32'h3F800002, 0, 1, 2);
        add(0, 9'h07F, mk(1, 23'h000000, 3'b100), 0, 32'h3F800000, 0, 1, 2);
        add(0, 9'h07F, mk(1, 23'h7FFFFF, 3'b110), 0, 32'h40000000, 0, 1, 3);
        add(0, 9'h0FE, mk(1, 23'h7FFFFF, 3'b100), 0, 32'h7F800000, 1, 1, 3);
        add(0, 9'h100, mk(1, 23'h123456, 3'b000), 0, 32'h7F800000, 1, 0, 2);
        add(1, 9'h080, mk(1, 23'h2AAAAA, 3'b011), 0, 32'hC02AAAAA, 0, 1, 2);
        add(0, 9'h000, mk(0, 23'h7FFFFF, 3'b110), 0, 32'h00800000, 0, 1, 2);
        add(0, 9'h0FE, mk(1, 23'h000000, 3'b000), 0, 32'h7F000000, 0, 0, 2);
        add(0, 9'h0FF, mk(1, 23'h000000, 3'b000), 0, 32'h7F800000, 1, 0, 2);
        add(0, 9'h07F, mk(1, 23'h000003, 3'b100), 0, 32'h3F800004, 0, 1, 2);
        add(0, 9'h07F, mk(1, 23'h000002, 3'b101), 0, 32'h3F800003, 0, 1, 2);
`ifdef FP_RND_MODES_EN
        add(0, 9'h07F, mk(1, 23'h7FFFFF, 3'b111), 1, 32'h3FFFFFFF, 0, 1, 2);
        add(1, 9'h0FE, mk(1, 23'h7FFFFF, 3'b100), 3, 32'hFF800000, 1, 1, 3);
        add(0, 9'h100, mk(1, 23'h000000, 3'b000), 1, 32'h7F7FFFFF, 1, 0, 2);
        add(1, 9'h0FF, mk(1, 23'h000000, 3'b000), 2, 32'hFF7FFFFF, 1, 0, 2);
        add(0, 9'h07F, mk(1, 23'h000000, 3'b001), 2, 32'h3F800001, 0, 1, 2);
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_flags", {30'b0, overflow, inexact}, 32'd0);
        res = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i].s, vecs[i].e, vecs[i].m, vecs[i].md, r, ov, ix, lat);
            chk($sformatf("vec%0d_result", i), r, vecs[i].r);
            chk($sformatf("vec%0d_overflow", i), {31'b0, ov}, {31'b0, vecs[i].ov});
            chk($sformatf("vec%0d_inexact", i), {31'b0, ix}, {31'b0, vecs[i].ix});
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        for (int i = 0; i < 150; i++) begin
            s = 1'($urandom % 2);
            k = int'($urandom % 8);
            if (k == 0)      e = 9'($urandom_range(0, 2));
            else if (k == 1) e = 9'($urandom_range(252, 256));
            else if (k == 2) e = 9'($urandom_range(256, 511));
            else             e = 9'($urandom_range(1, 253));
            f   = 23'($urandom);
            if ($urandom % 4 == 0) f = 23'h7FFFFF;
            grs = 3'($urandom);
            h   = (e == 9'd0) ? 1'($urandom % 2) : 1'b1;
`ifdef FP_RND_MODES_EN
            md  = 2'($urandom % 4);
`else
            md  = 2'd0;
`endif
            model(s, e, mk(h, f, grs), md, er, eov, eix, elat);
            apply(s, e, mk(h, f, grs), md, r, ov, ix, lat);
            chk($sformatf("rnd%0d_result", i), r, er);
            chk($sformatf("rnd%0d_flags", i), {30'b0, ov, ix}, {30'b0, eov, eix});
            chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(elat));
        end

        // Stall in DONE with a competing operand offered, then reset mid-hold
        @(posedge clk); #1;
        in_sign = 0; in_exp = 9'h07F; in_man = mk(1, 23'h000005, 3'b000); rnd_mode = 0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_man = mk(1, 23'h000009, 3'b000);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("stall_latency", 32'(lat), 32'd2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("stall%0d_state", i), {30'b0, out_valid, in_ready}, 32'b10);
            chk($sformatf("stall%0d_result", i), result, 32'h3F800005);
        end
        in_valid = 1'b0;
        res = 1'b0;
        #1;
        chk("async_reset_outputs", {result[31:0]}, 32'd0);
        chk("async_reset_ctrl", {28'b0, out_valid, in_ready, overflow, inexact}, 32'b0100);
        @(posedge clk); #1;
        res = 1'b1;
        model(0, 9'h080, mk(1, 23'h000010, 3'b110), 0, er, eov, eix, elat);
        apply(0, 9'h080, mk(1, 23'h000010, 3'b110), 0, r, ov, ix, lat);
        chk("post_reset_result", r, er);
        chk("post_reset_latency", 32'(lat), 32'(elat));

        // Drain cycle must not accept a new operand
        @(posedge clk); #1;
        in_exp = 9'h07F; in_man = mk(1, 23'h000001, 3'b000); in_valid = 1'b1;
        @(posedge clk); #1;
        in_man = mk(1, 23'h000011, 3'b100);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("drain_a_result", result, 32'h3F800001);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("no_accept_on_drain", {30'b0, out_valid, in_ready}, 32'b01);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("drain_b_latency", 32'(lat), 32'd2);
        chk("drain_b_result", result, 32'h3F800012);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset while the op is in ROUND discards it
        in_exp = 9'h07F; in_man = mk(1, 23'h000007, 3'b000); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        res = 1'b0;
        #1;
        chk("midop_reset_ctrl", {30'b0, out_valid, in_ready}, 32'b01);
        @(posedge clk); #1;
        res = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midop_discarded", {30'b0, out_valid, in_ready}, 32'b01);
        chk("midop_result_cleared", result, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
